switch_poll_controller: RTL and testbench

- Autonomous sequencer for the slider-switch parallel port. It acts as an Avalon-MM master that polls the port's data register (address 0) at a programmable interval.
- Each new sample is compared against the previous one. Changed bits are latched into a sticky edge-capture register, and a maskable interrupt is raised.
- A CPU-facing Avalon-MM slave exposes the last sample, the control/mask register, the poll period and the edge-capture register. The CPU no longer needs to busy-poll the switches.

---
 rtl/switch_poll_controller.sv | 105 ++++++++++
 tb/tb_switch_poll_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_poll_controller.sv
// Polls the slider-switch port at a programmable interval, latches changed bits
// into a sticky edge register and raises a maskable interrupt.
module switch_poll_controller #(
  parameter int DW = 9,
  parameter int PW = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        m_chipselect,
  output logic        m_read,
  output logic [1:0]  m_address,
  input  logic [31:0] m_readdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, COUNT, ISSUE, CAPTURE} state_t;

  localparam logic [PW:0] CNT_ONE = 1;

  state_t      state, state_nx;
  logic [DW:0] sample, mask, edge_q, new_smp, edge_set, edge_clr;
  logic [PW:0] period, cnt;
  logic        enable, prime, wr_en;
  logic [31:0] rd_mux;
  logic        unused_ok;

  // Reads load on chipselect alone; s_read and unmapped data bits carry no information.
  assign unused_ok = ^{s_read, m_readdata[31:DW+1], s_writedata[30:PW+1]};

  assign wr_en     = s_chipselect & s_write;
  assign m_address = 2'h0;
  assign new_smp   = m_readdata[DW:0];
  assign edge_set  = (state == CAPTURE && !prime) ? (new_smp ^ sample) : '0;
  assign edge_clr  = (wr_en && s_address == 2'd3) ? s_writedata[DW:0] : '0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = COUNT;
      COUNT:   if (!enable) state_nx = IDLE;
               else if (cnt == '0) state_nx = ISSUE;
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = enable ? COUNT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (s_address)
      2'd0: rd_mux[DW:0] = sample;
      2'd1: begin
        rd_mux[31]   = enable;
        rd_mux[DW:0] = mask;
      end
      2'd2: rd_mux[PW:0] = period;
      default: rd_mux[DW:0] = edge_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s_readdata   <= '0;
      m_chipselect <= 1'b0;
      m_read       <= 1'b0;
      irq          <= 1'b0;
      sample       <= '0;
      enable       <= 1'b0;
      mask         <= '0;
      period       <= '0;
      edge_q       <= '0;
      cnt          <= '0;
      prime        <= 1'b1;
    end else begin
      state        <= state_nx;
      m_chipselect <= (state_nx == ISSUE);
      m_read       <= (state_nx == ISSUE);
      irq          <= |(edge_q & mask);
      if (s_chipselect) s_readdata <= rd_mux;
      // A bit being set by this capture survives a simultaneous CPU clear.
      edge_q <= (edge_q & ~edge_clr) | edge_set;
      if (wr_en && s_address == 2'd1) begin
        enable <= s_writedata[31];
        mask   <= s_writedata[DW:0];
      end
      if (wr_en && s_address == 2'd2) period <= s_writedata[PW:0];
      if ((state == IDLE || state == CAPTURE) && enable) cnt <= period;
      else if (state == COUNT && enable && cnt != '0) cnt <= cnt - CNT_ONE;
      if (state == CAPTURE) begin
        sample <= new_smp;
        prime  <= 1'b0;
      end
      // Falling back to IDLE re-arms priming so a stale sample never records edges.
      if (state_nx == IDLE && state != IDLE) prime <= 1'b1;
    end
  end

endmodule

// File: tb/tb_switch_poll_controller.sv
// Bench for switch_poll_controller: timestamp-based poll model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_switch_poll_controller;
  localparam int DW = 9;
  localparam int PW = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  s_address = '0;
  logic        s_chipselect = 1'b0, s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        m_chipselect, m_read, irq;
  logic [1:0]  m_address;
  logic [31:0] m_readdata;
  logic [DW:0] sw = '0;
  logic [31-DW-1:0] junk = '0;

  assign m_readdata = {junk, sw};

  switch_poll_controller #(.DW(DW), .PW(PW)) dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_address(m_address),
    .m_readdata(m_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_WAIT, P_ISSUE, P_CAP} phase_t;
  phase_t      ph = P_IDLE;
  int          cyc = 0, t_issue = 0;
  bit          started = 0;
  logic [DW:0] e_sample = '0, e_mask = '0, e_edge = '0;
  logic [PW:0] e_period = '0;
  logic        e_en = 0, e_prime = 1, e_irq = 0, e_cs = 0;
  logic [31:0] e_rd = '0;

  task automatic model_step();
    logic [DW:0] nw, setb, clr;
    logic [31:0] rdv;
    logic        irq_nx;
    cyc++;
    started = 1;
    if (reset) begin
      ph = P_IDLE; e_sample = '0; e_mask = '0; e_edge = '0; e_period = '0;
      e_en = 0; e_prime = 1; e_irq = 0; e_cs = 0; e_rd = '0;
      return;
    end
    case (s_address)
      2'd0: rdv = 32'(e_sample);
      2'd1: rdv = {e_en, 21'b0, e_mask};
      2'd2: rdv = 32'(e_period);
      default: rdv = 32'(e_edge);
    endcase
    if (s_chipselect) e_rd = rdv;
    irq_nx = |(e_edge & e_mask);
    setb = '0;
    // Each reload at cycle r schedules the bus read at r+period+2.
    case (ph)
      P_IDLE: if (e_en) begin t_issue = cyc + int'(e_period) + 2; ph = P_WAIT; end
      P_WAIT: begin
        if (!e_en) begin ph = P_IDLE; e_prime = 1; end
        else if (cyc + 1 == t_issue) ph = P_ISSUE;
      end
      P_ISSUE: ph = P_CAP;
      P_CAP: begin
        nw = m_readdata[DW:0];
        if (!e_prime) setb = nw ^ e_sample;
        e_sample = nw;
        e_prime = 0;
        if (e_en) begin t_issue = cyc + int'(e_period) + 2; ph = P_WAIT; end
        else begin ph = P_IDLE; e_prime = 1; end
      end
    endcase
    clr = (s_chipselect && s_write && s_address == 2'd3) ? s_writedata[DW:0] : '0;
    e_edge = (e_edge & ~clr) | setb;
    if (s_chipselect && s_write && s_address == 2'd1) begin
      e_en = s_writedata[31]; e_mask = s_writedata[DW:0];
    end
    if (s_chipselect && s_write && s_address == 2'd2) e_period = s_writedata[PW:0];
    e_irq = irq_nx;
    e_cs = (ph == P_ISSUE);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare + poll monitor ----------------
  int ncyc = 0, last_cs = -1, spacing = 0, cs_cnt = 0;

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (m_chipselect === 1'b1) begin
      if (last_cs >= 0) spacing = ncyc - last_cs;
      last_cs = ncyc;
      cs_cnt++;
    end
    if (started) begin
      chk("m_chipselect", 32'(m_chipselect), 32'(e_cs));
      chk("m_read", 32'(m_read), 32'(e_cs));
      chk("m_address", 32'(m_address), 32'h0);
      chk("irq", 32'(irq), 32'(e_irq));
      chk("s_readdata", s_readdata, e_rd);
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_idle();
    s_chipselect = 0; s_read = 0; s_write = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    s_address = a; s_chipselect = 1; s_write = 1; s_writedata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    s_address = a; s_chipselect = 1; s_read = 1;
    @(negedge clk);
    bus_idle();
    d = s_readdata;
  endtask

  task automatic wait_cs();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (m_chipselect === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_cs: got no poll expected one within 40 cycles");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int base;

    repeat (3) @(negedge clk);
    reset = 0;

    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      chk("reset_read", d, 32'h0);
    end
    chk("reset_irq", 32'(irq), 32'h0);
    base = cs_cnt;
    repeat (50) @(negedge clk);
    chk("no_poll_when_disabled", 32'(cs_cnt - base), 32'h0);

    sw = 10'h155;
    wr(2'd2, 32'd4);
    wr(2'd1, 32'h8000_03FF);
    repeat (30) @(negedge clk);
    chk("poll_spacing", 32'(spacing), 32'd7);
    rd(2'd0, d); chk("sample_155", d, 32'h155);
    rd(2'd3, d); chk("prime_no_edge", d, 32'h0);
    chk("prime_irq", 32'(irq), 32'h0);

    sw = 10'h154;
    repeat (10) @(negedge clk);
    rd(2'd3, d); chk("edge_bit0", d, 32'h1);
    chk("irq_set", 32'(irq), 32'h1);
    wr(2'd3, 32'h1);
    repeat (2) @(negedge clk);
    rd(2'd3, d); chk("edge_cleared", d, 32'h0);
    chk("irq_cleared", 32'(irq), 32'h0);

    wr(2'd1, 32'h8000_0200);
    sw = 10'h155;
    repeat (10) @(negedge clk);
    rd(2'd3, d); chk("masked_edge", d, 32'h1);
    chk("masked_irq", 32'(irq), 32'h0);
    sw = 10'h355;
    repeat (10) @(negedge clk);
    rd(2'd3, d); chk("edge_201", d, 32'h201);
    chk("unmasked_irq", 32'(irq), 32'h1);

    wr(2'd3, 32'h3FF);
    sw = 10'h351;
    repeat (10) @(negedge clk);
    rd(2'd3, d); chk("edge_bit2", d, 32'h4);
    wait_cs();
    sw = 10'h353;
    wr(2'd3, 32'h6);
    rd(2'd3, d); chk("set_beats_clear", d, 32'h2);

    wait_cs();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    base = cs_cnt;
    repeat (30) @(negedge clk);
    chk("no_poll_after_reset", 32'(cs_cnt - base), 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      chk("post_reset_read", d, 32'h0);
    end

    wr(2'd2, 32'd100);
    wr(2'd1, 32'h8000_03FF);
    repeat (20) @(negedge clk);
    wr(2'd1, 32'h0);
    base = cs_cnt;
    sw = 10'h0AA;
    repeat (150) @(negedge clk);
    chk("disable_in_count", 32'(cs_cnt - base), 32'h0);
    wr(2'd2, 32'd3);
    wr(2'd1, 32'h8000_03FF);
    repeat (12) @(negedge clk);
    rd(2'd3, d); chk("reenable_prime", d, 32'h0);
    rd(2'd0, d); chk("reenable_sample", d, 32'h0AA);
    chk("reenable_irq", 32'(irq), 32'h0);

    // randomized traffic; the per-cycle model does the checking
    for (int i = 0; i < 600; i++) begin
      int act;
      act = int'($urandom_range(0, 99));
      junk = 22'($urandom);
      if (act < 25) sw = sw ^ 10'($urandom);
      else if (act < 35) wr(2'd1, {($urandom_range(0, 9) < 8), 21'b0, 10'($urandom)});
      else if (act < 42) wr(2'd2, 32'($urandom_range(0, 6)));
      else if (act < 52) wr(2'(act), 32'($urandom));
      else if (act < 75) rd(2'($urandom_range(0, 3)), d);
      else if (act < 76) begin
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
      end else repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
